// File: rtl/amstrad_mem_sched_if.sv
// rtl/amstrad_mem_sched_if.sv - memory-port bus between the slot scheduler and the SDRAM controller
interface amstrad_mem_sched_if #(
  parameter int AW = 23
);
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_wr;
  logic [1:0]    mem_be;
  logic [15:0]   mem_wdata;
  logic [15:0]   mem_rdata;
  logic          mem_ack;

  modport master (
    output mem_addr, mem_rd, mem_wr, mem_be, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_addr, mem_rd, mem_wr, mem_be, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/amstrad_mem_sched.sv
// rtl/amstrad_mem_sched.sv - time-slot scheduler sharing one memory port between video, Z80 and loader
// Owns the CPC bus phase counter and Z80 wait generation; one access outstanding at a time.
module amstrad_mem_sched #(
  parameter int AW          = 23,
  parameter int VID_AW      = 15,
  parameter int LOADER_PRIO = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                ce_4p,
  output logic [1:0]          phase,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [AW-1:0]       cpu_addr,
  input  logic [7:0]          cpu_wdata,
  output logic [7:0]          cpu_rdata,
  output logic                cpu_wait_n,
  input  logic [VID_AW-1:0]   vid_addr,
  output logic [15:0]         vid_data,
  output logic                vid_valid,
  output logic                vid_late,
  input  logic                ld_wr,
  input  logic [AW-1:0]       ld_addr,
  input  logic [7:0]          ld_data,
  output logic                ld_busy,
  amstrad_mem_sched_if.master mem
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_VID  = 2'd1,
    ST_CPU  = 2'd2,
    ST_LD   = 2'd3
  } state_e;

  localparam bit LD_FIRST = (LOADER_PRIO != 0);

  state_e        state_q, state_d;
  logic [1:0]    phase_q, phase_d;
  logic          vid_pend_q, vid_pend_d;
  logic          vid_late_q, vid_late_d;
  logic [15:0]   vid_data_q, vid_data_d;
  logic          vid_valid_q, vid_valid_d;
  logic [7:0]    cpu_rdata_q, cpu_rdata_d;
  logic          cpu_done_q, cpu_done_d;
  logic          ld_busy_q, ld_busy_d;
  logic [AW-1:0] ld_addr_q, ld_addr_d;
  logic [7:0]    ld_data_q, ld_data_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          mem_rd_q, mem_rd_d;
  logic          mem_wr_q, mem_wr_d;
  logic [1:0]    mem_be_q, mem_be_d;
  logic [15:0]   mem_wdata_q, mem_wdata_d;

  logic          ack;
  logic          ld_ack;
  logic          vid_edge;
  logic          vid_req;
  logic          cpu_elig;
  logic          cpu_pick;
  logic [AW-1:0] vid_byte_addr;

  // Acks outside an access (e.g. left over from before a reset) are ignored.
  assign ack           = mem.mem_ack & (state_q != ST_IDLE);
  assign ld_ack        = ack & (state_q == ST_LD);
  assign vid_edge      = ce_4p & (phase_q == 2'd3);
  assign vid_req       = vid_pend_q | vid_edge;
  assign cpu_elig      = cpu_req & ~cpu_done_q;
  assign cpu_pick      = cpu_elig & ~(LD_FIRST & ld_busy_q);
  assign vid_byte_addr = AW'({vid_addr, 1'b0});

  function automatic logic [1:0] lane_be(input logic a0);
    return a0 ? 2'b10 : 2'b01;
  endfunction

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    vid_pend_d  = vid_pend_q;
    vid_late_d  = vid_late_q;
    vid_data_d  = vid_data_q;
    vid_valid_d = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    cpu_done_d  = cpu_done_q & cpu_req;
    ld_busy_d   = ld_busy_q;
    ld_addr_d   = ld_addr_q;
    ld_data_d   = ld_data_q;
    mem_addr_d  = mem_addr_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;

    if (ce_4p) begin
      phase_d = phase_q + 2'd1;
    end
    if (vid_edge) begin
      vid_pend_d = 1'b1;
    end
    if (vid_req && (state_q != ST_IDLE)) begin
      vid_late_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (vid_req) begin
          state_d    = ST_VID;
          vid_pend_d = 1'b0;
          mem_addr_d = vid_byte_addr;
          mem_rd_d   = 1'b1;
          mem_wr_d   = 1'b0;
          mem_be_d   = 2'b11;
        end else if (cpu_pick) begin
          state_d     = ST_CPU;
          mem_addr_d  = cpu_addr;
          mem_rd_d    = ~cpu_we;
          mem_wr_d    = cpu_we;
          mem_be_d    = lane_be(cpu_addr[0]);
          mem_wdata_d = {cpu_wdata, cpu_wdata};
        end else if (ld_busy_q) begin
          state_d     = ST_LD;
          mem_addr_d  = ld_addr_q;
          mem_rd_d    = 1'b0;
          mem_wr_d    = 1'b1;
          mem_be_d    = lane_be(ld_addr_q[0]);
          mem_wdata_d = {ld_data_q, ld_data_q};
        end
      end
      default: begin
        if (ack) begin
          state_d  = ST_IDLE;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          if (state_q == ST_VID) begin
            vid_data_d  = mem.mem_rdata;
            vid_valid_d = 1'b1;
          end else if (state_q == ST_CPU) begin
            cpu_done_d = 1'b1;
            if (!mem_wr_q) begin
              cpu_rdata_d = mem_be_q[1] ? mem.mem_rdata[15:8] : mem.mem_rdata[7:0];
            end
          end else begin
            ld_busy_d = 1'b0;
          end
        end
      end
    endcase

    // The buffer frees on its own ack, so a strobe in that cycle is still taken.
    if (ld_wr && (!ld_busy_q || ld_ack)) begin
      ld_busy_d = 1'b1;
      ld_addr_d = ld_addr;
      ld_data_d = ld_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      phase_q     <= 2'd0;
      vid_pend_q  <= 1'b0;
      vid_late_q  <= 1'b0;
      vid_data_q  <= 16'd0;
      vid_valid_q <= 1'b0;
      cpu_rdata_q <= 8'd0;
      cpu_done_q  <= 1'b0;
      ld_busy_q   <= 1'b0;
      ld_addr_q   <= '0;
      ld_data_q   <= 8'd0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_be_q    <= 2'b00;
      mem_wdata_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      vid_pend_q  <= vid_pend_d;
      vid_late_q  <= vid_late_d;
      vid_data_q  <= vid_data_d;
      vid_valid_q <= vid_valid_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_done_q  <= cpu_done_d;
      ld_busy_q   <= ld_busy_d;
      ld_addr_q   <= ld_addr_d;
      ld_data_q   <= ld_data_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign phase         = phase_q;
  assign cpu_rdata     = cpu_rdata_q;
  assign cpu_wait_n    = ~(cpu_req & ~cpu_done_q & reset_n);
  assign vid_data      = vid_data_q;
  assign vid_valid     = vid_valid_q;
  assign vid_late      = vid_late_q;
  assign ld_busy       = ld_busy_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_rd    = mem_rd_q;
  assign mem.mem_wr    = mem_wr_q;
  assign mem.mem_be    = mem_be_q;
  assign mem.mem_wdata = mem_wdata_q;

endmodule
